sd_spi_block_master: RTL and testbench
======================================

Name: sd_spi_block_master

Overview:
- SPI-mode SD card command initiator. It serialises one 48-bit command frame, polls the R1 response and, for single-block reads (CMD17), captures the 0xFE start token, 512 data bytes and the 2 CRC bytes.
- It sits between the SD init/read sequencer and the card pins.
- Read bytes stream to the SDRAM write-buffer logic through a valid strobe.

Parameters:
- CLK_DIV, 2: clk cycles per spi_clk half-period (>=1).
- RESP_TIMEOUT, 16: maximum response-poll bytes before timeout.
- TOKEN_TIMEOUT, 1023: maximum bytes polled for the 0xFE token.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_req  in  1  one-cycle start pulse; sampled only when busy=0
- cmd_index  in  6  command number
- cmd_arg  in  32  command argument
- cmd_crc  in  8  CRC7 byte with end bit, sent verbatim
- cmd_rd_blk  in  1  command has a 512-byte data phase
- busy  out  1  transaction in progress
- done  out  1  one-cycle end pulse
- resp  out  8  R1 byte; valid from done until the next cmd_req
- err  out  2  0=ok, 1=response timeout, 2=token timeout, 3=data CRC error
- rd_data  out  8  received data byte
- rd_valid  out  1  one-cycle strobe per data byte (512 per block)
- spi_clk  out  1  SPI clock, idle low (mode 0)
- spi_cs_n  out  1  chip select
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
- Reset values: busy=0, done=0, resp=8'hFF, err=0, rd_data=0, rd_valid=0, spi_clk=0, spi_cs_n=1, spi_mosi=1.
- Reset mid-transaction returns all outputs to these values immediately; no partial done.
- Bit timing: one SPI bit = 2*CLK_DIV clk cycles.
  - spi_clk rises at the mid-bit point and falls at the bit end.
  - mosi changes only while spi_clk is low.
  - miso is sampled in the clk cycle where spi_clk rises.
- All bytes are MSB first. The bit counter is 3 bits and the byte counter is 10 bits.
- FSM: IDLE -> CMD -> GAP -> RESP -> (TOKEN -> DATA -> CRC) -> TAIL -> IDLE.
- IDLE: cmd_req with busy=0 latches index, arg, crc and rd_blk, sets busy and drives cs_n low in the next cycle. cmd_req while busy is ignored.
- CMD: sends 48 bits: {2'b01, index}, arg[31:0], crc.
- GAP: 8 clocks with mosi=1; miso is ignored.
- RESP: reads whole bytes with mosi=1.
  - The first byte with bit7=0 is stored in resp.
  - After RESP_TIMEOUT bytes with no such byte, set err=1 and go to TAIL.
  - If rd_blk=1 and resp=8'h00, go to TOKEN; otherwise go to TAIL.
- TOKEN: reads bytes until 8'hFE is seen. Any other value counts toward TOKEN_TIMEOUT; on expiry set err=2 and go to TAIL.
- DATA: 512 bytes.
  - Each completed byte drives rd_data and pulses rd_valid one clk cycle later.
  - Back-to-back strobes are exactly 16*CLK_DIV clk cycles apart.
- CRC: reads 2 bytes; handling is defined under Optional Feature.
- TAIL: cs_n goes high, then 8 clocks with mosi=1.
  - busy clears and done pulses in the same cycle, one clk after the last spi_clk falling edge.
  - cmd_req is accepted again from the cycle after done.
- Frame length with no data phase: 48 + 8 + 8*N_resp + 8 SPI clocks.

Optional Feature:
- Macro SD_CRC16_CHK_EN.
- When defined, a CRC16-CCITT (poly 0x1021, init 0) runs over the 512 data bytes. A mismatch with the received CRC bytes sets err=3 at done; rd_valid strobes are unaffected.
- When undefined, the CRC bytes are clocked in and discarded and err is never 3.

Test Plan:
- CMD0, arg=0, crc=8'h95, rd_blk=0; card model answers 0x01 after 10 extra 0xFF bytes:
  - mosi carries 0x40 00 00 00 00 95;
  - resp=0x01, err=0, single done, 0 rd_valid.
- CMD17, arg=32'h0000_2000, rd_blk=1; card answers 0x00, then 0xFE, then bytes j[7:0] for j=512..1:
  - exactly 512 rd_valid pulses with data 0x00, 0xFF, 0xFE, ..., 0x01;
  - err=0.
- Card never drives miso low (held at 1):
  - done after RESP_TIMEOUT response bytes, err=1, resp=0xFF, cs_n high.
- CMD17 with response 0x00 but no token:
  - err=2 after 1023 token bytes, no rd_valid.
- Assert rst_n low during the DATA phase at byte 100:
  - outputs go to reset values immediately;
  - a new CMD17 afterwards completes normally.
- SD_CRC16_CHK_EN defined with a corrupted CRC byte:
  - err=3, all 512 strobes still delivered.
- cmd_req pulsed while busy:
  - ignored; exactly one done.

Source files
------------

// File: rtl/sd_spi_block_master.sv
// SPI-mode SD command initiator: 48-bit command frame, R1 poll and optional CMD17 block read.
// Define SD_CRC16_CHK_EN to check the data-block CRC16-CCITT (err=3 on mismatch).
module sd_spi_block_master #(
   parameter int CLK_DIV       = 2,
   parameter int RESP_TIMEOUT  = 16,
   parameter int TOKEN_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_req,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [7:0]  cmd_crc,
   input  logic        cmd_rd_blk,
   output logic        busy,
   output logic        done,
   output logic [7:0]  resp,
   output logic [1:0]  err,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        spi_clk,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   // state   | meaning
   // S_IDLE  | waiting for cmd_req, cs_n high
   // S_CMD   | shifting out the 6-byte command frame
   // S_GAP   | one byte of mosi=1, miso ignored
   // S_RESP  | polling for an R1 byte (bit7=0)
   // S_TOKEN | polling for the 0xFE start token
   // S_DATA  | receiving 512 data bytes
   // S_CRC   | receiving the 2 data CRC bytes
   // S_TAIL  | cs_n high, 8 trailing clocks
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_GAP, S_RESP, S_TOKEN, S_DATA, S_CRC, S_TAIL
   } state_t;

   localparam int            DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LOAD   = DW'(CLK_DIV - 1);
   localparam logic [9:0]    RESP_LOAD  = 10'(RESP_TIMEOUT - 1);
   localparam logic [9:0]    TOKEN_LOAD = 10'(TOKEN_TIMEOUT - 1);

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [9:0]    byte_cnt;
   logic [47:0]   tx;
   logic [7:0]    rx;
   logic [7:0]    rx_next;
   logic          rd_blk;
   logic          fin;

   assign rx_next = {rx[6:0], spi_miso};

`ifdef SD_CRC16_CHK_EN
   logic [15:0] crc_calc;
   logic [7:0]  crc_hi;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= 3'd7;
         byte_cnt <= '0;
         tx       <= '1;
         rx       <= 8'hFF;
         rd_blk   <= 1'b0;
         fin      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         resp     <= 8'hFF;
         err      <= 2'd0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
         spi_clk  <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_mosi <= 1'b1;
`ifdef SD_CRC16_CHK_EN
         crc_calc <= '0;
         crc_hi   <= '0;
`endif
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         if (state == S_IDLE) begin
            if (cmd_req) begin
               state    <= S_CMD;
               busy     <= 1'b1;
               spi_cs_n <= 1'b0;
               tx       <= {2'b01, cmd_index, cmd_arg, cmd_crc};
               spi_mosi <= 1'b0;
               rd_blk   <= cmd_rd_blk;
               resp     <= 8'hFF;
               err      <= 2'd0;
               div_cnt  <= DIV_LOAD;
               bit_cnt  <= 3'd7;
               byte_cnt <= 10'd5;
`ifdef SD_CRC16_CHK_EN
               crc_calc <= '0;
`endif
            end
         end else if (fin) begin
            // one clk after the final falling edge of the tail byte
            fin   <= 1'b0;
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
         end else begin
            div_cnt <= DIV_LOAD;
            if (!spi_clk) begin
               spi_clk <= 1'b1;
               rx      <= rx_next;
               if (state == S_DATA && bit_cnt == 3'd0) begin
                  rd_data  <= rx_next;
                  rd_valid <= 1'b1;
`ifdef SD_CRC16_CHK_EN
                  crc_calc <= crc16_byte(crc_calc, rx_next);
`endif
               end
            end else begin
               spi_clk  <= 1'b0;
               tx       <= {tx[46:0], 1'b1};
               spi_mosi <= tx[46];
               bit_cnt  <= bit_cnt - 1'b1;
               if (bit_cnt == 3'd0) begin
                  byte_cnt <= byte_cnt - 1'b1;
                  case (state)
                     S_CMD: begin
                        if (byte_cnt == '0) state <= S_GAP;
                     end
                     S_GAP: begin
                        state    <= S_RESP;
                        byte_cnt <= RESP_LOAD;
                     end
                     S_RESP: begin
                        if (!rx[7]) begin
                           resp <= rx;
                           if (rd_blk && rx == 8'h00) begin
                              state    <= S_TOKEN;
                              byte_cnt <= TOKEN_LOAD;
                           end else begin
                              state    <= S_TAIL;
                              spi_cs_n <= 1'b1;
                           end
                        end else if (byte_cnt == '0) begin
                           err      <= 2'd1;
                           state    <= S_TAIL;
                           spi_cs_n <= 1'b1;
                        end
                     end
                     S_TOKEN: begin
                        if (rx == 8'hFE) begin
                           state    <= S_DATA;
                           byte_cnt <= 10'd511;
                        end else if (byte_cnt == '0) begin
                           err      <= 2'd2;
                           state    <= S_TAIL;
                           spi_cs_n <= 1'b1;
                        end
                     end
                     S_DATA: begin
                        if (byte_cnt == '0) begin
                           state    <= S_CRC;
                           byte_cnt <= 10'd1;
                        end
                     end
                     S_CRC: begin
                        if (byte_cnt == '0) begin
`ifdef SD_CRC16_CHK_EN
                           if ({crc_hi, rx} != crc_calc) err <= 2'd3;
`endif
                           state    <= S_TAIL;
                           spi_cs_n <= 1'b1;
                        end else begin
`ifdef SD_CRC16_CHK_EN
                           crc_hi <= rx;
`endif
                        end
                     end
                     S_TAIL: begin
                        fin <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_block_master.sv
// Scoreboard bench for sd_spi_block_master: card model on the SPI pins, expected
// results computed from the command/response rules and checked by a monitor.
module tb_sd_spi_block_master;
   localparam int CLK_DIV       = 2;
   localparam int RESP_TIMEOUT  = 16;
   localparam int TOKEN_TIMEOUT = 1023;
   localparam int WAIT_LIM      = 40000;

   logic        clk;
   logic        rst_n;
   logic        cmd_req;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [7:0]  cmd_crc;
   logic        cmd_rd_blk;
   logic        busy;
   logic        done;
   logic [7:0]  resp;
   logic [1:0]  err;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        spi_clk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;

   sd_spi_block_master #(
      .CLK_DIV       (CLK_DIV),
      .RESP_TIMEOUT  (RESP_TIMEOUT),
      .TOKEN_TIMEOUT (TOKEN_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_req    (cmd_req),
      .cmd_index  (cmd_index),
      .cmd_arg    (cmd_arg),
      .cmd_crc    (cmd_crc),
      .cmd_rd_blk (cmd_rd_blk),
      .busy       (busy),
      .done       (done),
      .resp       (resp),
      .err        (err),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .spi_clk    (spi_clk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   typedef struct {
      logic [7:0]  resp;
      logic [1:0]  err;
      int          ndata;
      logic [47:0] frame;
      int          clocks;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  exp_data[$];
   logic [7:0]  card_q[$];
   int          total = 0;
   int          bad = 0;
   int          nvalid = 0;
   int          done_cnt = 0;
   int          frame_rises = 0;
   logic [47:0] mosi_cap = '0;
   int          mosi_n = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] sb(input int i);
      if (i < card_q.size()) return card_q[i];
      return 8'hFF;
   endfunction

   function automatic logic card_bit(input int idx);
      logic [7:0] b;
      if (idx < 56) return 1'b1;
      b = sb((idx - 56) / 8);
      return b[3'(7 - ((idx - 56) % 8))];
   endfunction

   // remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
   function automatic logic [15:0] crc16(input logic [7:0] d[$]);
      logic [16:0] r;
      r = '0;
      foreach (d[i]) begin
         for (int k = 7; k >= 0; k--) begin
            r = {r[15:0], d[i][k]};
            if (r[16]) r = r ^ 17'h11021;
         end
      end
      for (int k = 0; k < 16; k++) begin
         r = {r[15:0], 1'b0};
         if (r[16]) r = r ^ 17'h11021;
      end
      return r[15:0];
   endfunction

   task automatic build_block(input logic corrupt);
      logic [7:0]  blk[$];
      logic [15:0] c;
      card_q.delete();
      card_q.push_back(8'h00);
      card_q.push_back(8'hFE);
      for (int j = 512; j >= 1; j--) blk.push_back(8'(j));
      c = crc16(blk);
      if (corrupt) c[0] = ~c[0];
      foreach (blk[i]) card_q.push_back(blk[i]);
      card_q.push_back(c[15:8]);
      card_q.push_back(c[7:0]);
   endtask

   task automatic push_expected(input logic [5:0] idx, input logic [31:0] arg,
                                input logic [7:0] crc, input logic rdb);
      exp_t       t;
      int         n;
      logic [7:0] b;
      logic       hit;
`ifdef SD_CRC16_CHK_EN
      logic [7:0] blk[$];
`endif
      t.resp  = 8'hFF;
      t.err   = 2'd0;
      t.ndata = 0;
      t.frame = {2'b01, idx, arg, crc};
      n   = 0;
      hit = 1'b0;
      for (int i = 0; i < RESP_TIMEOUT && !hit; i++) begin
         b = sb(n);
         n++;
         if (!b[7]) begin
            hit    = 1'b1;
            t.resp = b;
         end
      end
      if (!hit) t.err = 2'd1;
      else if (rdb && t.resp == 8'h00) begin
         hit = 1'b0;
         for (int i = 0; i < TOKEN_TIMEOUT && !hit; i++) begin
            b = sb(n);
            n++;
            if (b == 8'hFE) hit = 1'b1;
         end
         if (!hit) t.err = 2'd2;
         else begin
            for (int i = 0; i < 512; i++) begin
               exp_data.push_back(sb(n));
`ifdef SD_CRC16_CHK_EN
               blk.push_back(sb(n));
`endif
               n++;
            end
            t.ndata = 512;
`ifdef SD_CRC16_CHK_EN
            if ({sb(n), sb(n + 1)} != crc16(blk)) t.err = 2'd3;
`endif
            n += 2;
         end
      end
      t.clocks = 48 + 8 + 8 * n + 8;
      exp_q.push_back(t);
   endtask

   task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] crc, input logic rdb);
      push_expected(idx, arg, crc, rdb);
      @(posedge clk);
      #1;
      cmd_index  = idx;
      cmd_arg    = arg;
      cmd_crc    = crc;
      cmd_rd_blk = rdb;
      cmd_req    = 1'b1;
      @(posedge clk);
      #1;
      cmd_req = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int   start;
      logic ok;
      start = done_cnt;
      ok    = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         @(negedge clk);
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, ".done_seen"}, ok, 1);
      repeat (3) @(posedge clk);
   endtask

   task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc, input logic rdb);
      issue(idx, arg, crc, rdb);
      wait_done(name);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".busy"},     busy,     0);
      check({tag, ".done"},     done,     0);
      check({tag, ".resp"},     resp,     8'hFF);
      check({tag, ".err"},      err,      0);
      check({tag, ".rd_data"},  rd_data,  0);
      check({tag, ".rd_valid"}, rd_valid, 0);
      check({tag, ".spi_clk"},  spi_clk,  0);
      check({tag, ".spi_cs_n"}, spi_cs_n, 1);
      check({tag, ".spi_mosi"}, spi_mosi, 1);
   endtask

   // card: drives miso after each spi_clk fall, records mosi on each rise
   initial begin : card
      int   bit_idx;
      logic prev_sclk;
      logic prev_cs;
      logic prev_busy;
      bit_idx   = 0;
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      prev_busy = 1'b0;
      spi_miso  = 1'b1;
      forever begin
         @(negedge clk);
         if (busy && !prev_busy) frame_rises = 0;
         if (!prev_sclk && spi_clk) begin
            if (busy) frame_rises++;
            if (!spi_cs_n && mosi_n < 48) begin
               mosi_cap = {mosi_cap[46:0], spi_mosi};
               mosi_n++;
            end
         end
         if (!spi_cs_n && prev_cs) begin
            bit_idx  = 0;
            mosi_n   = 0;
            spi_miso = card_bit(0);
         end else if (!spi_cs_n && prev_sclk && !spi_clk) begin
            bit_idx++;
            spi_miso = card_bit(bit_idx);
         end
         if (spi_cs_n) spi_miso = 1'b1;
         prev_sclk = spi_clk;
         prev_cs   = spi_cs_n;
         prev_busy = busy;
      end
   end

   initial begin : monitor
      int         cyc;
      int         last_v;
      exp_t       t;
      logic [7:0] e;
      cyc    = 0;
      last_v = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            if (exp_q.size() > 0) exp_q.delete(0);
            exp_data.delete();
            nvalid = 0;
            continue;
         end
         if (rd_valid) begin
            if (exp_data.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rd_valid: actual=strobe data=%0h expected=no strobe", rd_data);
            end else begin
               e = exp_data.pop_front();
               check("rd_data", rd_data, e);
            end
            if (nvalid > 0) check("strobe_gap", cyc - last_v, 16 * CLK_DIV);
            last_v = cyc;
            nvalid++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done: actual=pulse expected=no pulse");
            end else begin
               t = exp_q.pop_front();
               check("resp",      resp,        t.resp);
               check("err",       err,         t.err);
               check("n_valid",   nvalid,      t.ndata);
               check("mosi_cmd",  mosi_cap,    t.frame);
               check("n_clocks",  frame_rises, t.clocks);
               check("cs_n_done", spi_cs_n,    1);
               check("busy_done", busy,        0);
            end
            nvalid = 0;
            done_cnt++;
         end
      end
   end

   initial begin : stim
      logic       ok;
      int         start;
      int         n;
      logic [7:0] b;
      rst_n      = 1'b0;
      cmd_req    = 1'b0;
      cmd_index  = '0;
      cmd_arg    = '0;
      cmd_crc    = '0;
      cmd_rd_blk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      card_q.delete();
      repeat (10) card_q.push_back(8'hFF);
      card_q.push_back(8'h01);
      run_cmd("cmd0", 6'd0, 32'h0, 8'h95, 1'b0);

      build_block(1'b0);
      run_cmd("cmd17", 6'd17, 32'h0000_2000, 8'hFF, 1'b1);

      card_q.delete();
      run_cmd("resp_to", 6'd17, 32'h0000_4000, 8'hFF, 1'b1);

      card_q.delete();
      card_q.push_back(8'h00);
      run_cmd("token_to", 6'd17, 32'h0000_6000, 8'hFF, 1'b1);

      build_block(1'b0);
      issue(6'd17, 32'h0000_8000, 8'hFF, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         @(negedge clk);
         if (nvalid >= 100) begin
            ok = 1'b1;
            break;
         end
      end
      check("mid_rst.reach_byte100", ok, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      build_block(1'b1);
      run_cmd("crc_bad", 6'd17, 32'h0000_2000, 8'hFF, 1'b1);

      card_q.delete();
      card_q.push_back(8'h01);
      start = done_cnt;
      issue(6'd0, 32'h0, 8'h95, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      cmd_index  = 6'd17;
      cmd_arg    = 32'hDEAD_BEEF;
      cmd_rd_blk = 1'b1;
      cmd_req    = 1'b1;
      @(posedge clk);
      #1;
      cmd_req = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      cmd_req = 1'b1;
      @(posedge clk);
      #1;
      cmd_req = 1'b0;
      wait_done("busy_req");
      repeat (400) @(negedge clk);
      check("busy_req.n_done", done_cnt - start, 1);
      check("busy_req.busy", busy, 0);

      for (int r = 0; r < 5; r++) begin
         card_q.delete();
         n = $urandom_range(0, 18);
         for (int i = 0; i < n; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            card_q.push_back(b);
         end
         run_cmd("rand", 6'($urandom_range(0, 63)), $urandom, 8'($urandom_range(0, 255)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
